rv_muldiv_unit: RTL
===================

// Module: rv_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide execution unit, parametrised in XLEN.
//  Sits beside the core ALU. The core control stalls the PC while BUSY is high
//  and writes RESULT back on DONE. Decodes funct3 exactly as the M extension.
//  One radix-2 step per cycle: shift-add for multiply, restoring for divide.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, even)
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > XLEN
// PORTS
//  CLK     in   1     clock, rising edge
//  RESET   in   1     asynchronous, active-low reset
//  START   in   1     request; sampled only in IDLE or DONE state
//  FLUSH   in   1     abort current op (pipeline redirect)
//  F3      in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  SRC_A   in   XLEN  rs1 operand (multiplicand / dividend)
//  SRC_B   in   XLEN  rs2 operand (multiplier / divisor)
//  BUSY    out  1     op in flight (CALC or FIX)
//  DONE    out  1     one-cycle pulse; RESULT valid
//  RESULT  out  XLEN  result; held until next accepted START
// BEHAVIOUR
//  - Reset (RESET=0, async): state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0.
//  - States:
//    - IDLE -START-> CALC.
//    - CALC -(counter==XLEN-1)-> FIX.
//    - FIX -> DONE.
//    - DONE -START-> CALC, else -> IDLE.
//  - Accept edge: on the edge where START=1 in IDLE/DONE, latch F3, the operand
//    magnitudes, and sign flags.
//    - MULH and DIV/REM: both operands signed.
//    - MULHSU: only SRC_A signed.
//    - Unsigned ops: no sign.
//  - Latency: DONE=1 in the cycle XLEN+2 edges after the accept edge (34 for XLEN=32).
//  - BUSY=1 in every cycle between accept and DONE.
//  - START while BUSY is ignored, with no queueing.
//  - Multiply: 2*XLEN-bit unsigned product of magnitudes, negated in FIX when the
//    signs differ.
//    - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
//  - Divide: unsigned quotient/remainder of magnitudes. In FIX, negate:
//    - the quotient if the signs differ;
//    - the remainder if the dividend is negative.
//  - Divide by zero (SRC_B==0):
//    - DIV/DIVU: quotient = all ones.
//    - REM/REMU: remainder = SRC_A.
//  - Signed overflow (DIV/REM with SRC_A=-2^(XLEN-1), SRC_B=-1):
//    - quotient = SRC_A, remainder = 0.
//  - FLUSH=1 on any edge returns to IDLE next cycle.
//    - BUSY=0, no DONE, RESULT keeps its previous value.
//    - FLUSH with START on the same edge: FLUSH wins and the op is not accepted.
//  - RESULT updates only on the FIX->DONE edge.
//  - Operand changes after the accept edge have no effect.
//  - Reset mid-operation aborts immediately with the reset values above.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//    - Ops skip CALC and go IDLE/DONE -> FIX -> DONE, so DONE fires 2 cycles after accept:
//      - divide by zero;
//      - signed overflow;
//      - multiply with either operand 0.
//    - The special-case result is selected directly.
//  MULDIV_EARLY_OUT_EN undefined:
//    - These ops run the full XLEN+2 latency.
//    - Results are bit-identical to the defined build.
// TESTING
//  1. MUL 7*-3 (XLEN=32): RESULT=0xFFFFFFEB, DONE exactly 34 cycles after START,
//     BUSY high 33 cycles.
//  2. MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF:
//     RESULT=0x00000000 / 0x80000000 / 0x7FFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIV 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//     Latency 34 without MULDIV_EARLY_OUT_EN, 2 with it.
//  5. FLUSH at cycle 10 of a DIV:
//     - BUSY=0 next cycle, no DONE;
//     - RESULT unchanged;
//     - new START next cycle completes normally.
//     START asserted mid-op: ignored.
//  6. RESET low at cycle 5 of a MUL:
//     - BUSY/DONE/RESULT=0 without waiting for an edge;
//     - back-to-back START in the DONE cycle is accepted, with DONE again 34 cycles later.

Source files
------------

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to bypass CALC for div-by-zero, signed overflow and zero-operand multiply.
module rv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_src_a;
  logic [XLEN-1:0]   r_result;
  logic [2:0]        r_f3;
  logic              r_sign_a, r_neg, r_div0, r_ovf, r_mul0;

  logic              w_accept, w_skip;
  logic              w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div0, w_ovf, w_mul0;

  assign w_accept   = i_start & ~i_flush & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_a_signed = (i_f3 == 3'b001) | (i_f3 == 3'b010) | (i_f3[2] & ~i_f3[0]);
  assign w_b_signed = (i_f3 == 3'b001) | (i_f3[2] & ~i_f3[0]);
  assign w_sign_a   = w_a_signed & i_src_a[XLEN-1];
  assign w_sign_b   = w_b_signed & i_src_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -i_src_a : i_src_a;
  assign w_mag_b    = w_sign_b ? -i_src_b : i_src_b;
  assign w_div0     = i_f3[2] & (i_src_b == '0);
  assign w_ovf      = i_f3[2] & ~i_f3[0] & (i_src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_src_b);
  assign w_mul0     = ~i_f3[2] & ((i_src_a == '0) | (i_src_b == '0));

`ifdef MULDIV_EARLY_OUT_EN
  assign w_skip = w_div0 | w_ovf | w_mul0;
`else
  assign w_skip = 1'b0;
`endif

  // Multiply step: r_acc = {partial high, remaining multiplier bits}
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: r_acc = {partial remainder, dividend shifting into quotient}
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_div_next;
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_result;
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Special cases are selected from flags so both builds give identical results
  always_comb begin
    w_fix_result = '0;
    if (r_f3[2]) begin
      if (r_div0)
        w_fix_result = r_f3[1] ? r_src_a : '1;
      else if (r_ovf)
        w_fix_result = r_f3[1] ? '0 : r_src_a;
      else
        w_fix_result = r_f3[1] ? w_rem : w_quo;
    end else if (!r_mul0) begin
      w_fix_result = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_next = w_accept ? (w_skip ? S_FIX : S_CALC) : S_IDLE;
      S_CALC:         if (r_cnt == CNT_W'(XLEN-1)) w_state_next = S_FIX;
      S_FIX:          w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
    if (i_flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_src_a  <= '0;
      r_result <= '0;
      r_f3     <= '0;
      r_sign_a <= 1'b0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mul0   <= 1'b0;
    end else if (w_accept) begin
      r_f3     <= i_f3;
      r_sign_a <= w_sign_a;
      r_neg    <= w_sign_a ^ w_sign_b;
      r_src_a  <= i_src_a;
      r_div0   <= w_div0;
      r_ovf    <= w_ovf;
      r_mul0   <= w_mul0;
      r_cnt    <= '0;
      if (i_f3[2]) begin
        r_acc <= {{XLEN{1'b0}}, w_mag_a};
        r_b   <= w_mag_b;
      end else begin
        r_acc <= {{XLEN{1'b0}}, w_mag_b};
        r_b   <= w_mag_a;
      end
    end else if (r_state == S_CALC && !i_flush) begin
      r_acc <= r_f3[2] ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == S_FIX && !i_flush) begin
      r_result <= w_fix_result;
    end
  end

  assign o_busy   = (r_state == S_CALC) | (r_state == S_FIX);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule
